// File: rtl/chip_top_wrapper.sv
// JTAG test access port: 16-state TAP controller, instruction register and
// BYPASS / IDCODE / USER data registers, all clocked from TCK.
module chip_top_wrapper #(
    parameter int                    IR_WIDTH     = 5,
    parameter logic [31:0]           IDCODE_VALUE = 32'h1234_5093,
    parameter int                    USER_WIDTH   = 5,
    parameter logic [USER_WIDTH-1:0] USER_RESET   = 5'h1F
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    output logic [USER_WIDTH-1:0] USER_DR_OUT
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} dr_sel_e;

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(2);

    tap_state_e            state;
    logic [IR_WIDTH-1:0]   ir;
    logic [IR_WIDTH-1:0]   ir_sr;
    logic                  bypass_sr;
    logic [31:0]           id_sr;
    logic [USER_WIDTH-1:0] user_sr;
    logic [USER_WIDTH-1:0] user_q;
    dr_sel_e               dr_sel;
    logic                  tdo_nxt;

    function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
        case (s)
            TLR:     return tms ? TLR    : RTI;
            RTI:     return tms ? SEL_DR : RTI;
            SEL_DR:  return tms ? SEL_IR : CAP_DR;
            CAP_DR:  return tms ? EX1_DR : SH_DR;
            SH_DR:   return tms ? EX1_DR : SH_DR;
            EX1_DR:  return tms ? UPD_DR : PAU_DR;
            PAU_DR:  return tms ? EX2_DR : PAU_DR;
            EX2_DR:  return tms ? UPD_DR : SH_DR;
            UPD_DR:  return tms ? SEL_DR : RTI;
            SEL_IR:  return tms ? TLR    : CAP_IR;
            CAP_IR:  return tms ? EX1_IR : SH_IR;
            SH_IR:   return tms ? EX1_IR : SH_IR;
            EX1_IR:  return tms ? UPD_IR : PAU_IR;
            PAU_IR:  return tms ? EX2_IR : PAU_IR;
            EX2_IR:  return tms ? UPD_IR : SH_IR;
            UPD_IR:  return tms ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

    // Unknown opcodes fall back to BYPASS so TDI->TDO always has a path.
    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir == OP_IDCODE)
            dr_sel = SEL_IDCODE;
        else if (ir == OP_USER)
            dr_sel = SEL_USER;
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state     <= TLR;
            ir        <= OP_IDCODE;
            ir_sr     <= OP_IDCODE;
            bypass_sr <= 1'b0;
            id_sr     <= '0;
            user_sr   <= USER_RESET;
            user_q    <= USER_RESET;
        end else begin
            state <= next_state(state, TMS);
            case (state)
                CAP_IR: ir_sr <= OP_IDCODE;
                SH_IR:  ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
                UPD_IR: ir    <= ir_sr;
                CAP_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: id_sr     <= IDCODE_VALUE;
                        SEL_USER:   user_sr   <= user_q;
                        default:    bypass_sr <= 1'b0;
                    endcase
                end
                SH_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: id_sr     <= {TDI, id_sr[31:1]};
                        SEL_USER:   user_sr   <= {TDI, user_sr[USER_WIDTH-1:1]};
                        default:    bypass_sr <= TDI;
                    endcase
                end
                UPD_DR: if (dr_sel == SEL_USER) user_q <= user_sr;
                default: ;
            endcase
            // Entering (or sitting in) TLR restores reset values; placed last so it wins.
            if (next_state(state, TMS) == TLR) begin
                ir     <= OP_IDCODE;
                user_q <= USER_RESET;
            end
        end
    end

    always_comb begin
        tdo_nxt = 1'b0;
        if (state == SH_IR)
            tdo_nxt = ir_sr[0];
        else if (state == SH_DR) begin
            case (dr_sel)
                SEL_IDCODE: tdo_nxt = id_sr[0];
                SEL_USER:   tdo_nxt = user_sr[0];
                default:    tdo_nxt = bypass_sr;
            endcase
        end
    end

    always_ff @(negedge TCK) TDO <= tdo_nxt;

    assign USER_DR_OUT = user_q;

endmodule

// File: tb/tb_chip_top_wrapper.sv
// Directed bench for the JTAG TAP wrapper: IDCODE read, IR load, BYPASS,
// USER update, TMS-driven reset and TRST mid-shift.
module tb_chip_top_wrapper;

    logic       TCK = 1'b0;
    logic       TRST, TMS, TDI;
    logic       TDO;
    logic [4:0] USER_DR_OUT;

    int errors = 0;
    int checks = 0;

    chip_top_wrapper dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .USER_DR_OUT(USER_DR_OUT)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive TMS/TDI, take one rising edge, then sample after the falling edge.
    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    // From TLR or RTI: walk to Shift-DR, collect 32 TDO bits, return to RTI.
    task automatic read_idcode(input string tag);
        logic [31:0] word;
        tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        word[0] = TDO;
        for (int i = 1; i < 32; i++) begin
            tick(0, 0);
            word[i] = TDO;
        end
        check(tag, word, 32'h1234_5093);
        tick(1, 0); tick(1, 0); tick(0, 0);
    endtask

    initial begin
        logic [7:0] byp_in;
        logic [4:0] usr_in;
        byp_in = 8'b1011_1100;   // sent LSB first: 0,0,1,1,1,1,0,1
        usr_in = 5'b01010;       // sent LSB first: 0,1,0,1,0

        TRST = 1'b1; TMS = 1'b1; TDI = 1'b0;
        @(posedge TCK); @(negedge TCK); #1;
        TRST = 1'b0;
        check("reset_tdo", 32'(TDO), 32'h0);
        check("reset_user", 32'(USER_DR_OUT), 32'h1F);

        read_idcode("idcode_after_trst");

        // IR load of all ones -> BYPASS; captured 00001 appears first
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        check("ir_cap_tdo0", 32'(TDO), 32'h1);
        for (int i = 1; i < 5; i++) begin
            tick(0, 1);
            check($sformatf("ir_cap_tdo%0d", i), 32'(TDO), 32'h0);
        end
        tick(0, 1); tick(0, 1);
        tick(1, 1); tick(1, 0); tick(0, 0);

        // BYPASS: captured 0, then TDI delayed by one edge
        tick(1, 0); tick(0, 0); tick(0, 0);
        check("byp_cap", 32'(TDO), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(0, byp_in[i]);
            check($sformatf("byp_bit%0d", i), 32'(TDO), 32'(byp_in[i]));
        end
        tick(1, 0);
        check("byp_exit1_tdo", 32'(TDO), 32'h0);
        tick(1, 0); tick(0, 0);

        // Load IR = USER (00010), TDI order 0,1,0,0,0, last bit on exit edge
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 0); tick(0, 1); tick(0, 0); tick(0, 0); tick(1, 0);
        tick(1, 0); tick(0, 0);

        // USER DR: capture 1F, shift in 01010, update
        tick(1, 0); tick(0, 0); tick(0, 0);
        check("usr_tdo0", 32'(TDO), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick(0, usr_in[i]);
            check($sformatf("usr_tdo%0d", i + 1), 32'(TDO), 32'h1);
        end
        tick(1, usr_in[4]);
        tick(1, 0);
        check("usr_before_update", 32'(USER_DR_OUT), 32'h1F);
        tick(0, 0);
        check("usr_after_update", 32'(USER_DR_OUT), 32'h0A);

        // Five TMS=1 edges from Shift-DR reach TLR and restore defaults
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) tick(1, 1);
        check("tms_reset_user", 32'(USER_DR_OUT), 32'h1F);
        check("tms_reset_tdo", 32'(TDO), 32'h0);
        read_idcode("idcode_after_tms_reset");

        // Load USER again, then TRST in the middle of a Shift-IR
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 0); tick(0, 1); tick(0, 0); tick(0, 0); tick(1, 0);
        tick(1, 0); tick(0, 0);
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0);
        tick(1, 0); tick(1, 0); tick(0, 0);
        check("usr_zero_update", 32'(USER_DR_OUT), 32'h0);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 1); tick(0, 1);
        TRST = 1'b1;
        tick(0, 1);
        TRST = 1'b0;
        check("trst_mid_tdo", 32'(TDO), 32'h0);
        check("trst_mid_user", 32'(USER_DR_OUT), 32'h1F);
        read_idcode("idcode_after_trst_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
